// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response, redirect and decode handshake bundle.
// The master modport is the fetch unit side; slave is the memory/branch/decode environment.
interface fetch_unit_if #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 7,
    parameter int PC_WIDTH        = 32
);
    logic                       imem_request;
    logic [INST_ADDR_WIDTH-1:0] imem_addr;
    logic                       imem_valid;
    logic [INST_WIDTH-1:0]      imem_inst;
    logic                       redirect_valid;
    logic [PC_WIDTH-1:0]        redirect_pc;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [INST_WIDTH-1:0]      dec_inst;
    logic [PC_WIDTH-1:0]        dec_pc;

    modport master (
        output imem_request, imem_addr, dec_valid, dec_inst, dec_pc,
        input  imem_valid, imem_inst, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_request, imem_addr, dec_valid, dec_inst, dec_pc,
        output imem_valid, imem_inst, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues imem reads and queues returned instructions for decode.
// Defining FETCH_STALL_CNT_EN adds a saturating decode-starvation counter on stall_cycles.
module fetch_unit #(
    parameter int          INST_WIDTH      = 32,
    parameter int          INST_ADDR_WIDTH = 7,
    parameter int          PC_WIDTH        = 32,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int          QUEUE_DEPTH     = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cycles
`endif
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(QUEUE_DEPTH);

    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_reqPc;
    logic                  r_inflight;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [INST_WIDTH-1:0] r_instMem [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]   r_pcMem   [QUEUE_DEPTH];

    logic [CNT_W:0]        w_occupancy;
    logic                  w_request;
    logic                  w_push;
    logic                  w_pop;
    logic [PC_WIDTH-1:0]   w_redirectPc;

    // A request is a reserved FIFO slot, so queued entries plus the one in the memory pipe must fit.
    assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_request    = !rst && !bus.redirect_valid && (w_occupancy < DEPTH_LIMIT);
    assign w_push       = !rst && !bus.redirect_valid && bus.imem_valid && r_inflight;
    assign w_pop        = !rst && !bus.redirect_valid && bus.dec_ready && (r_count != '0);
    assign w_redirectPc = bus.redirect_pc & ~PC_WIDTH'(3);

    assign bus.imem_request = w_request;
    assign bus.imem_addr    = r_pc[INST_ADDR_WIDTH+1:2];
    assign bus.dec_valid    = (r_count != '0);
    assign bus.dec_inst     = r_instMem[r_rdPtr];
    assign bus.dec_pc       = r_pcMem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= PC_WIDTH'(RESET_PC);
            r_reqPc    <= '0;
            r_inflight <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc       <= w_redirectPc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_request;
            if (w_request) begin
                r_pc    <= r_pc + PC_WIDTH'(4);
                r_reqPc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.redirect_valid) begin
            r_count <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instMem[r_wrPtr] <= bus.imem_inst;
            r_pcMem[r_wrPtr]   <= r_reqPc;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stallCycles;

    // Counts cycles where decode was ready but had nothing to take; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
        end else if (bus.dec_ready && (r_count == '0) && !bus.redirect_valid
                     && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign stall_cycles = r_stallCycles;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a credit/stream reference model.
// With FETCH_STALL_CNT_EN defined the stall_cycles counter is checked as well.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fetch_unit_if #(.INST_WIDTH(32), .INST_ADDR_WIDTH(7), .PC_WIDTH(32)) bus ();

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stallCycles;
    logic [31:0] sStall;
    int          mStall;
`endif

    fetch_unit #(
        .INST_WIDTH(32), .INST_ADDR_WIDTH(7), .PC_WIDTH(32),
        .RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles(stallCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [128];
    bit          spurious;

    logic        sReq, sValid, eReq, eValid;
    logic [6:0]  sAddr, eAddr;
    logic [31:0] sPc, sInst, ePc, eInst;

    int          mIssued, mPopped;
    bit          mLastIssued;
    logic [31:0] mReqPc, mDelPc;

    // One clock: sample outputs mid-cycle, advance the stream model, then play the 1-cycle memory.
    task automatic applyStimulus();
        logic        rstS, redS, rdyS;
        logic [31:0] rpcS;
        #2;
        rstS   = rst;
        redS   = bus.redirect_valid;
        rdyS   = bus.dec_ready;
        rpcS   = bus.redirect_pc;
        eReq   = !rstS && !redS && ((mIssued - mPopped) < DEPTH);
        eValid = (mIssued - mPopped - (mLastIssued ? 1 : 0)) > 0;
        eAddr  = mReqPc[8:2];
        ePc    = mDelPc;
        eInst  = mem[mDelPc[8:2]];
        sReq   = bus.imem_request;
        sAddr  = bus.imem_addr;
        sValid = bus.dec_valid;
        sPc    = bus.dec_pc;
        sInst  = bus.dec_inst;
`ifdef FETCH_STALL_CNT_EN
        sStall = stallCycles;
`endif
        @(posedge clk);
        if (rstS || redS) begin
            mReqPc      = rstS ? RESET_PC : {rpcS[31:2], 2'b00};
            mDelPc      = mReqPc;
            mIssued     = 0;
            mPopped     = 0;
            mLastIssued = 1'b0;
        end else begin
            if (eValid && rdyS) begin
                mDelPc  = mDelPc + 32'd4;
                mPopped = mPopped + 1;
            end
            if (eReq) begin
                mReqPc  = mReqPc + 32'd4;
                mIssued = mIssued + 1;
            end
            mLastIssued = eReq;
        end
`ifdef FETCH_STALL_CNT_EN
        if (rstS) mStall = 0;
        else if (rdyS && !eValid && !redS) mStall = mStall + 1;
`endif
        #1;
        bus.imem_valid = sReq || (spurious && ($urandom_range(0, 3) == 0));
        bus.imem_inst  = sReq ? mem[sAddr] : $urandom();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.dec_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        applyStimulus();
        applyStimulus();
        vectors++;
        if (sReq !== 1'b0) begin
            miscompares++; $display("[TB] FAIL resetRequest: got %b want 0", sReq);
        end
        vectors++;
        if (sValid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL resetDecValid: got %b want 0", sValid);
        end
    endtask

    task automatic test_cold_start();
        rst = 1'b0;
        bus.dec_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            vectors++;
            if (sReq !== 1'b1 || sAddr !== 7'(c)) begin
                miscompares++;
                $display("[TB] FAIL coldRequest cyc %0d: got req=%b addr=%h want req=1 addr=%h", c, sReq, sAddr, 7'(c));
            end
            vectors++;
            if (sValid !== (c >= 2)) begin
                miscompares++; $display("[TB] FAIL coldDecValid cyc %0d: got %b want %b", c, sValid, (c >= 2));
            end
            if (c >= 2) begin
                vectors++;
                if (sPc !== 32'((c - 2) * 4) || sInst !== 32'(32'h1000 + c - 2)) begin
                    miscompares++;
                    $display("[TB] FAIL coldDecode cyc %0d: got pc=%h inst=%h want pc=%h inst=%h",
                             c, sPc, sInst, 32'((c - 2) * 4), 32'(32'h1000 + c - 2));
                end
            end
`ifdef FETCH_STALL_CNT_EN
            if (c == 2) begin
                vectors++;
                if (sStall !== 32'd2) begin
                    miscompares++; $display("[TB] FAIL coldStallCycles: got %0d want 2", sStall);
                end
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        int reqCount;
        int got;
        int firstAddr;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        bus.dec_ready = 1'b0;
        reqCount = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus();
            if (sReq === 1'b1) reqCount++;
        end
        vectors++;
        if (reqCount != DEPTH || sReq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bpRequests: got count=%0d lastReq=%b want count=%0d lastReq=0", reqCount, sReq, DEPTH);
        end
        bus.dec_ready = 1'b1;
        got = 0;
        firstAddr = -1;
        for (int c = 0; c < 16 && got < 8; c++) begin
            applyStimulus();
            if (sReq === 1'b1 && firstAddr < 0) firstAddr = int'(sAddr);
            if (sValid === 1'b1) begin
                vectors++;
                if (sPc !== 32'(got * 4) || sInst !== 32'(32'h1000 + got)) begin
                    miscompares++;
                    $display("[TB] FAIL bpOrder #%0d: got pc=%h inst=%h want pc=%h inst=%h",
                             got, sPc, sInst, 32'(got * 4), 32'(32'h1000 + got));
                end
                got++;
            end
        end
        vectors++;
        if (got != 8 || firstAddr != 4) begin
            miscompares++;
            $display("[TB] FAIL bpResume: got delivered=%0d firstAddr=%0d want delivered=8 firstAddr=4", got, firstAddr);
        end
    endtask

    task automatic test_redirect();
        bit seen;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        bus.dec_ready = 1'b0;
        for (int c = 0; c < 4; c++) applyStimulus();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h43;
        applyStimulus();
        vectors++;
        if (sReq !== 1'b0) begin
            miscompares++; $display("[TB] FAIL redirRequest: got %b want 0", sReq);
        end
        bus.redirect_valid = 1'b0;
        applyStimulus();
        vectors++;
        if (sValid !== 1'b0 || sReq !== 1'b1 || sAddr !== 7'h10) begin
            miscompares++;
            $display("[TB] FAIL redirAfter: got valid=%b req=%b addr=%h want valid=0 req=1 addr=10", sValid, sReq, sAddr);
        end
        bus.dec_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            applyStimulus();
            if (sValid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || sPc !== 32'h40 || sInst !== 32'h1010) begin
            miscompares++;
            $display("[TB] FAIL redirFirst: got seen=%b pc=%h inst=%h want seen=1 pc=40 inst=1010", seen, sPc, sInst);
        end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h1F8;
        bus.dec_ready = 1'b1;
        applyStimulus();
        bus.redirect_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            if (c < 3) begin
                vectors++;
                if (sReq !== 1'b1 || sAddr !== 7'((126 + c) % 128)) begin
                    miscompares++;
                    $display("[TB] FAIL wrapAddr cyc %0d: got req=%b addr=%h want req=1 addr=%h", c, sReq, sAddr, 7'((126 + c) % 128));
                end
            end
            if (c >= 2) begin
                vectors++;
                if (sValid !== 1'b1 || sPc !== 32'(32'h1F8 + 4 * (c - 2))
                    || sInst !== 32'(32'h1000 + (124 + c) % 128)) begin
                    miscompares++;
                    $display("[TB] FAIL wrapDecode cyc %0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", c, sValid, sPc,
                             sInst, 32'(32'h1F8 + 4 * (c - 2)), 32'(32'h1000 + (124 + c) % 128));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int got;
        rst = 1'b0;
        bus.dec_ready = 1'b0;
        for (int c = 0; c < 4; c++) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        vectors++;
        if (sReq !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midRstRequest: got %b want 0", sReq);
        end
        rst = 1'b0;
        applyStimulus();
        vectors++;
        if (sValid !== 1'b0 || sReq !== 1'b1 || sAddr !== RESET_PC[8:2]) begin
            miscompares++;
            $display("[TB] FAIL midRstRestart: got valid=%b req=%b addr=%h want valid=0 req=1 addr=%h",
                     sValid, sReq, sAddr, RESET_PC[8:2]);
        end
        bus.dec_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            applyStimulus();
            if (sValid === 1'b1) begin
                vectors++;
                if (sPc !== RESET_PC + 32'(4 * got) || sInst !== 32'(32'h1000 + got)) begin
                    miscompares++;
                    $display("[TB] FAIL midRstDeliver #%0d: got pc=%h inst=%h want pc=%h inst=%h",
                             got, sPc, sInst, RESET_PC + 32'(4 * got), 32'(32'h1000 + got));
                end
                got++;
            end
        end
        vectors++;
        if (got != 2) begin
            miscompares++; $display("[TB] FAIL midRstTimeout: got %0d deliveries want 2", got);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 128; i++) mem[i] = $urandom();
        spurious = 1'b1;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        applyStimulus();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.redirect_valid = !rst && ($urandom_range(0, 24) == 0);
            bus.redirect_pc = $urandom();
            bus.dec_ready = ($urandom_range(0, 9) < 7);
            applyStimulus();
            vectors++;
            if (sReq !== eReq) begin
                miscompares++; $display("[TB] FAIL rndRequest cyc %0d: got %b want %b", c, sReq, eReq);
            end
            if (eReq) begin
                vectors++;
                if (sAddr !== eAddr) begin
                    miscompares++; $display("[TB] FAIL rndAddr cyc %0d: got %h want %h", c, sAddr, eAddr);
                end
            end
            vectors++;
            if (sValid !== eValid) begin
                miscompares++; $display("[TB] FAIL rndDecValid cyc %0d: got %b want %b", c, sValid, eValid);
            end
            if (eValid) begin
                vectors++;
                if (sPc !== ePc || sInst !== eInst) begin
                    miscompares++;
                    $display("[TB] FAIL rndDecode cyc %0d: got pc=%h inst=%h want pc=%h inst=%h", c, sPc, sInst, ePc, eInst);
                end
            end
`ifdef FETCH_STALL_CNT_EN
            vectors++;
            if (sStall !== 32'(mStall)) begin
                miscompares++; $display("[TB] FAIL rndStall cyc %0d: got %0d want %0d", c, sStall, mStall);
            end
`endif
        end
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        spurious = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        spurious = 1'b0;
        rst = 1'b1;
        bus.imem_valid = 1'b0;
        bus.imem_inst = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready = 1'b0;
        mIssued = 0;
        mPopped = 0;
        mLastIssued = 1'b0;
        mReqPc = RESET_PC;
        mDelPc = RESET_PC;
`ifdef FETCH_STALL_CNT_EN
        mStall = 0;
`endif
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + 32'(i);
        test_reset();
        test_cold_start();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
